mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_array.sv | 32 +++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: word type, memory-map constants,
// FSM state encoding and the address range helper.
package mem_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t STACK_START_POINT = 16'h00FE;
  localparam word_t ENTRY_POINT       = 16'h0020;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // One access as seen on the bus at the capture edge.
  typedef struct packed {
    word_t addr;
    word_t data;
    logic  write;
  } access_t;

  // True when the word address falls inside a RAM of 2^addr_w words.
  function automatic logic addr_in_range(input word_t addr, input int addr_w);
    if (addr_w >= WORD_W) return 1'b1;
    return (addr >> addr_w) == '0;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> memory responder bus: master drives address/data/direction,
// slave returns read data plus the completion and fault strobes.
interface mem_responder_if;

  mem_pkg::word_t addr;
  mem_pkg::word_t data_in;
  logic           memory_w;
  mem_pkg::word_t data_out;
  logic           memory_ready;
  logic           mem_error;

  modport master (
    output addr, data_in, memory_w,
    input  data_out, memory_ready, mem_error
  );

  modport slave (
    input  addr, data_in, memory_w,
    output data_out, memory_ready, mem_error
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with a registered read port and no reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  word_t             wdata_i,
  output word_t             rdata_o
);

  word_t mem_q [2**ADDR_W];
  word_t rdata_q;

  // NOTE: the array and its read register carry no reset on purpose; RAM
  // contents must survive rst_n, and a reset port would prevent RAM mapping.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: captures a CPU access every IDLE edge, waits
// WAIT_STATES cycles, then completes it. Optional MEM_RESPONDER_WPROT_EN
// write-protects 16'h0000..ENTRY_POINT-1.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  access_t    acc_q, acc_d;
  access_t    cur;
  logic       ready_q, ready_d;
  logic       err_q, err_d;
  logic       rd_valid_q, rd_valid_d;

  logic       in_rng;
  logic       prot;
  logic       enter_done;
  logic       ram_en;
  word_t      ram_rdata;

  // In IDLE the live bus is the access; afterwards the captured copy governs,
  // so bus changes during WAIT/DONE have no effect.
  always_comb begin
    if (state_q == IDLE) begin
      cur.addr  = bus.addr;
      cur.data  = bus.data_in;
      cur.write = bus.memory_w;
    end else begin
      cur = acc_q;
    end
  end

  assign in_rng = addr_in_range(cur.addr, ADDR_W);

`ifdef MEM_RESPONDER_WPROT_EN
  assign prot = cur.write && (cur.addr < ENTRY_POINT);
`else
  assign prot = 1'b0;
`endif

  // NOTE: every always_comb output is given a default before the case so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        acc_d = cur;
        if (WAIT_STATES == 0) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The access takes effect on the edge that enters DONE.
  assign enter_done = (state_d == DONE);
  assign ram_en     = enter_done && in_rng && !prot;

  always_comb begin
    ready_d    = enter_done;
    err_d      = enter_done && (!in_rng || prot);
    rd_valid_d = rd_valid_q;
    if (enter_done && !cur.write) begin
      rd_valid_d = in_rng;
    end
  end

  // NOTE: state elements use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      acc_q      <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (cur.write),
    .addr_i  (cur.addr[ADDR_W-1:0]),
    .wdata_i (cur.data),
    .rdata_o (ram_rdata)
  );

  // The RAM read register only updates on reads; rd_valid_q zeroes the output
  // after reset and after an out-of-range read.
  assign bus.data_out     = rd_valid_q ? ram_rdata : '0;
  assign bus.memory_ready = ready_q;
  assign bus.mem_error    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_STATES=2 and 0) share one bus
// stimulus and are checked against a period-based access model every cycle.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int AW   = 8;
  localparam int WS_A = 2;
  localparam int WS_B = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_t b_addr = '0;
  word_t b_data = '0;
  logic  b_w    = 1'b0;

  mem_responder_if ifa ();
  mem_responder_if ifb ();

  assign ifa.addr = b_addr;  assign ifa.data_in = b_data;  assign ifa.memory_w = b_w;
  assign ifb.addr = b_addr;  assign ifb.data_in = b_data;  assign ifb.memory_w = b_w;

  mem_responder #(.ADDR_W(AW), .WAIT_STATES(WS_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  mem_responder #(.ADDR_W(AW), .WAIT_STATES(WS_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  logic  rdy [2];
  logic  err [2];
  word_t dout[2];
  assign rdy[0] = ifa.memory_ready;  assign err[0] = ifa.mem_error;  assign dout[0] = ifa.data_out;
  assign rdy[1] = ifb.memory_ready;  assign err[1] = ifb.mem_error;  assign dout[1] = ifb.data_out;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic int ws(input int i);
    return (i == 0) ? WS_A : WS_B;
  endfunction

  // Model: after reset, edge n captures when n % (WS+2) == 0 and the access
  // completes (outputs visible for one cycle) after edge n % (WS+2) == WS.
  word_t mem_m [2][256];
  bit    mv    [2][256];
  int    n_m   [2];
  word_t ca [2], cd [2];
  bit    cw [2];
  bit    ex_rdy [2], ex_err [2], ex_known [2];
  word_t ex_dout [2];
  int    ph;
  bit    inr, pr;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        n_m[i] = 0; ex_rdy[i] = 0; ex_err[i] = 0; ex_dout[i] = '0; ex_known[i] = 1;
      end else begin
        ph = n_m[i] % (ws(i) + 2);
        ex_rdy[i] = 0;
        ex_err[i] = 0;
        if (ph == 0) begin
          ca[i] = b_addr; cd[i] = b_data; cw[i] = b_w;
        end
        if (ph == ws(i)) begin
          inr = (ca[i] < 16'h0100);
          pr  = 0;
`ifdef MEM_RESPONDER_WPROT_EN
          pr  = cw[i] && (ca[i] < ENTRY_POINT);
`endif
          ex_rdy[i] = 1;
          ex_err[i] = !inr || pr;
          if (cw[i]) begin
            if (inr && !pr) begin
              mem_m[i][ca[i][7:0]] = cd[i];
              mv[i][ca[i][7:0]]    = 1;
            end
          end else if (!inr) begin
            ex_dout[i] = '0; ex_known[i] = 1;
          end else begin
            ex_dout[i] = mem_m[i][ca[i][7:0]]; ex_known[i] = mv[i][ca[i][7:0]];
          end
        end
        n_m[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model_ready[%0d] t=%0t", i, $time), 16'(rdy[i]), 16'(ex_rdy[i]));
        check($sformatf("model_error[%0d] t=%0t", i, $time), 16'(err[i]), 16'(ex_err[i]));
        if (ex_known[i])
          check($sformatf("model_data[%0d] t=%0t", i, $time), dout[i], ex_dout[i]);
      end
    end
  end

  // Snapshots of the four cycles of one aligned access window.
  logic  s_rdy_a [4], s_err_a [4], s_rdy_b [4];
  word_t s_dout_a [4];

  task automatic access(input word_t a, input word_t d, input logic w);
    b_addr = a; b_data = d; b_w = w;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      s_rdy_a[k] = rdy[0]; s_err_a[k] = err[0]; s_dout_a[k] = dout[0]; s_rdy_b[k] = rdy[1];
    end
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 16'(rdy[0]), 16'h0);
    check("reset_error", 16'(err[0]), 16'h0);
    check("reset_data",  dout[0],     16'h0000);
    check("reset_ready_b", 16'(rdy[1]), 16'h0);
    chk_en = 1;
    #1 rst_n = 1'b1;

    access(16'h0005, 16'hBEEF, 1'b1);
    check("wr_ready_latency", 16'(s_rdy_a[2]), 16'h1);
    check("wr_no_early_ready", 16'(s_rdy_a[1]), 16'h0);
    check("wr_keeps_data_out", s_dout_a[2], 16'h0000);

    access(16'h0005, 16'h0000, 1'b0);
    check("rd_no_early_ready", 16'(s_rdy_a[1]), 16'h0);
    check("rd_ready_3_after",  16'(s_rdy_a[2]), 16'h1);
    check("rd_ready_one_cycle", 16'(s_rdy_a[3]), 16'h0);
    check("rd_beef", s_dout_a[2], 16'hBEEF);
    check("ws0_ready_c0", 16'(s_rdy_b[0]), 16'h1);
    check("ws0_ready_c1", 16'(s_rdy_b[1]), 16'h0);
    check("ws0_ready_c2", 16'(s_rdy_b[2]), 16'h1);

    access(STACK_START_POINT, 16'h1234, 1'b1);
    check("wr_done_data_held", s_dout_a[2], 16'hBEEF);
    access(STACK_START_POINT, 16'h0000, 1'b0);
    check("raw_1234", s_dout_a[2], 16'h1234);

    access(16'h0105, 16'hAAAA, 1'b1);
    check("oor_wr_error", 16'(s_err_a[2]), 16'h1);
    access(16'h0100, 16'h0000, 1'b0);
    check("oor_rd_ready", 16'(s_rdy_a[2]), 16'h1);
    check("oor_rd_error", 16'(s_err_a[2]), 16'h1);
    check("oor_rd_zero",  s_dout_a[2], 16'h0000);
    access(16'h0005, 16'h0000, 1'b0);
    check("oor_wr_discarded", s_dout_a[2], 16'hBEEF);

    // Reset during WAIT of a write to 16'h0030.
    access(16'h0030, 16'h1111, 1'b1);
    b_addr = 16'h0030; b_data = 16'h5555; b_w = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ready", 16'(rdy[0]), 16'h0);
    end
    #1 rst_n = 1'b1;
    access(16'h0030, 16'h0000, 1'b0);
    check("abort_ready_after_restart", 16'(s_rdy_a[2]), 16'h1);
    check("abort_ram_unchanged", s_dout_a[2], 16'h1111);

    access(16'h0010, 16'h0A0A, 1'b1);
    access(16'h0010, 16'hFFFF, 1'b1);
`ifdef MEM_RESPONDER_WPROT_EN
    check("wprot_error", 16'(s_err_a[2]), 16'h1);
`else
    check("wprot_off_no_error", 16'(s_err_a[2]), 16'h0);
    access(16'h0010, 16'h0000, 1'b0);
    check("wprot_off_write_lands", s_dout_a[2], 16'hFFFF);
`endif

    // Address changes while the access is already captured.
    b_addr = 16'h0005; b_data = 16'h0000; b_w = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ws0_done_data", dout[1], 16'hBEEF);
    #1 b_addr = STACK_START_POINT;
    @(posedge clk); @(negedge clk);
    check("ws0_idle_no_ready", 16'(rdy[1]), 16'h0);
    @(posedge clk); @(negedge clk);
    check("ignore_addr_change", dout[0], 16'hBEEF);
    check("ws0_next_access", dout[1], 16'h1234);
    @(posedge clk); @(negedge clk);
    #1;

    repeat (3000) begin
      if ($urandom_range(0, 9) == 0) b_addr = 16'($urandom) | 16'h0100;
      else                           b_addr = 16'($urandom_range(0, 63));
      b_data = 16'($urandom);
      b_w    = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      #1;
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
